hyperram_arbiter: RTL and testbench

HYPERRAM_ARBITER -- requirements
Module: hyperram_arbiter

---
 rtl/hyperram_arbiter.sv | 144 ++++++++++++++
 tb/tb_hyperram_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_arbiter.sv
// hyperram_arbiter
// Shares one HyperRAM controller between three requesters
// (0 = instruction fetch, 1 = data memory, 2 = DMA).
// A round-robin grant is taken in IDLE, the command is presented in ISSUE,
// and the data phase is forwarded in XFER.
// A watchdog aborts a data phase that stalls for TIMEOUT cycles.
//
// Ports
//   clk, rst        : single rising-edge clock; asynchronous active-high reset
//   req_*           : packed per-requester request channel; slice i is at [i*W +: W]
//   wr_data/wr_ready: per-requester write beat data and the consume strobe
//   rd_data/rd_valid: shared read data bus and per-requester valid strobes
//   done, err       : burst-complete pulse per requester; err marks an aborted burst
//   err_cnt         : saturating count of aborted bursts
//   mem_*           : controller-side command and data channel
module hyperram_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [2:0]          req_we,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*LEN_W-1:0]  req_len,
  input  logic [3*DATA_W-1:0] wr_data,
  output logic [2:0]          wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic [2:0]          rd_valid,
  output logic [2:0]          done,
  output logic                err,
  output logic [7:0]          err_cnt,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [LEN_W-1:0]    mem_len,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_wready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  input  logic                mem_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  grant;
  logic [1:0]  ptr;
  logic [1:0]  pick;
  logic [1:0]  cand1;
  logic [1:0]  cand2;
  logic [15:0] wdog;
  logic [2:0]  grant_oh;
  logic        in_issue;
  logic        in_xfer;
  logic        abort;
  logic        finish;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Round-robin search: ptr first, then the two requesters after it.
  always_comb begin
    cand1 = inc3(ptr);
    cand2 = inc3(cand1);
    pick  = cand2;
    if (req_valid[ptr])
      pick = ptr;
    else if (req_valid[cand1])
      pick = cand1;
  end

  assign in_issue = (state == ISSUE);
  assign in_xfer  = (state == XFER);
  assign grant_oh = 3'b001 << grant;

  // The watchdog only fires if this cycle brings neither a beat nor mem_done,
  // so a controller answering on the last allowed cycle is not punished.
  assign abort  = in_xfer && !mem_done && !mem_rvalid && !mem_wready && (wdog == WD_LIMIT);
  assign finish = in_xfer && (mem_done || abort);

  // Command side is only driven while ISSUE holds the grant.
  assign mem_valid = in_issue;
  assign mem_we    = in_issue & req_we[grant];
  assign mem_addr  = in_issue ? req_addr[grant*ADDR_W +: ADDR_W] : '0;
  assign mem_len   = in_issue ? req_len[grant*LEN_W +: LEN_W] : '0;
  assign req_ready = (in_issue && mem_ready) ? grant_oh : 3'b000;

  // Data side forwards controller strobes only during XFER.
  assign mem_wdata = in_xfer ? wr_data[grant*DATA_W +: DATA_W] : '0;
  assign wr_ready  = (in_xfer && mem_wready) ? grant_oh : 3'b000;
  assign rd_data   = in_xfer ? mem_rdata : '0;
  assign rd_valid  = (in_xfer && mem_rvalid) ? grant_oh : 3'b000;
  assign done      = finish ? grant_oh : 3'b000;
  assign err       = abort;

  // Arbitration FSM. Finishing a burst always returns to IDLE, so a fresh
  // grant is at least one cycle after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 2'd0;
      ptr     <= 2'd0;
      wdog    <= 16'd0;
      err_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant <= pick;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            wdog  <= 16'd0;
            state <= XFER;
          end
        end
        XFER: begin
          if (finish) begin
            state <= IDLE;
            ptr   <= inc3(grant);
            if (abort && (err_cnt != 8'hFF))
              err_cnt <= err_cnt + 8'd1;
          end else if (mem_rvalid || mem_wready) begin
            wdog <= 16'd0;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperram_arbiter.sv
// tb_hyperram_arbiter
// Directed bench for hyperram_arbiter with TIMEOUT=16. Stimulus tasks play
// the requesters and the controller and push expected events into a queue.
// A negedge monitor pops one entry for every command acceptance, write beat,
// read beat and done it observes on the DUT. Direct checks cover reset,
// issue latency, idle gaps, stray strobes and the watchdog timing.
module tb_hyperram_arbiter;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req_valid;
  logic [2:0]      req_ready;
  logic [2:0]      req_we;
  logic [3*AW-1:0] req_addr;
  logic [3*LW-1:0] req_len;
  logic [3*DW-1:0] wr_data;
  logic [2:0]      wr_ready;
  logic [DW-1:0]   rd_data;
  logic [2:0]      rd_valid;
  logic [2:0]      done;
  logic            err;
  logic [7:0]      err_cnt;
  logic            mem_valid;
  logic            mem_ready;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [LW-1:0]   mem_len;
  logic [DW-1:0]   mem_wdata;
  logic            mem_wready;
  logic [DW-1:0]   mem_rdata;
  logic            mem_rvalid;
  logic            mem_done;

  hyperram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err), .err_cnt(err_cnt),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_len(mem_len), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  // kind: 0 = command accepted, 1 = write beat, 2 = read beat, 3 = done
  typedef struct {
    int          kind;
    int          req;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [AW-1:0] baddr[3];
  logic [LW-1:0] blen[3];
  logic          bwe[3];
  logic [DW-1:0] bwd[3];

  function automatic exp_t mk(input int kind, input int req, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.kind = kind;
    e.req  = req;
    e.a    = a;
    e.b    = b;
    return e;
  endfunction

  function automatic int oh_idx(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < 3; i++) begin
      req_addr[i*AW +: AW] = baddr[i];
      req_len[i*LW +: LW]  = blen[i];
      req_we[i]            = bwe[i];
      wr_data[i*DW +: DW]  = bwd[i];
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic scoreEvent(input int kind, input int req, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_event: got kind=%0d req=%0d a=%0h b=%0h expected none", kind, req, a, b);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.req != req || e.a !== a || e.b !== b) begin
        errors++;
        $display("[TB] FAIL event: got kind=%0d req=%0d a=%0h b=%0h expected kind=%0d req=%0d a=%0h b=%0h",
                 kind, req, a, b, e.kind, e.req, e.a, e.b);
      end
    end
  endtask

  // Monitor: compares every observed handshake against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (req_ready != 3'b000)
        scoreEvent(0, oh_idx(req_ready), {9'd0, mem_addr}, {27'd0, mem_we, mem_len});
      if (wr_ready != 3'b000)
        scoreEvent(1, oh_idx(wr_ready), 32'd0, mem_wdata);
      if (rd_valid != 3'b000)
        scoreEvent(2, oh_idx(rd_valid), 32'd0, rd_data);
      if (done != 3'b000)
        scoreEvent(3, oh_idx(done), 32'd0, {31'd0, err});
      else if (err !== 1'b0)
        checkOutput("err_without_done", {63'd0, err}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serves one burst for requester g, starting in an IDLE cycle with
  // req_valid[g] already set. combine puts mem_done on the last beat.
  task automatic serve(input int g, input bit combine, input bit drop);
    int n;
    n = int'(blen[g]) + 1;
    checkOutput("idle_gap_mem_valid", {63'd0, mem_valid}, 64'd0);
    sb.push_back(mk(0, g, {9'd0, baddr[g]}, {27'd0, bwe[g], blen[g]}));
    tick();
    checkOutput("issue_latency_mem_valid", {63'd0, mem_valid}, 64'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    if (drop) req_valid = 3'b000;
    for (int k = 0; k < n; k++) begin
      if (bwe[g]) begin
        bwd[g] = 32'hD000_0000 + (g << 8) + k;
        applyStimulus();
        mem_wready = 1'b1;
        sb.push_back(mk(1, g, 32'd0, bwd[g]));
      end else begin
        mem_rdata  = 32'hA000_0000 + (g << 8) + k;
        mem_rvalid = 1'b1;
        sb.push_back(mk(2, g, 32'd0, mem_rdata));
      end
      if (combine && k == n - 1) begin
        mem_done = 1'b1;
        sb.push_back(mk(3, g, 32'd0, 32'd0));
      end
      tick();
      mem_rvalid = 1'b0;
      mem_wready = 1'b0;
      mem_done   = 1'b0;
      if (bwe[g] && k < n - 1) tick();
    end
    if (!combine) begin
      mem_done = 1'b1;
      sb.push_back(mk(3, g, 32'd0, 32'd0));
      tick();
      mem_done = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int seen;
    rst        = 1'b1;
    req_valid  = 3'b000;
    mem_ready  = 1'b0;
    mem_wready = 1'b0;
    mem_rvalid = 1'b0;
    mem_done   = 1'b0;
    mem_rdata  = '0;
    for (int i = 0; i < 3; i++) begin
      baddr[i] = '0;
      blen[i]  = '0;
      bwe[i]   = 1'b0;
      bwd[i]   = '0;
    end
    applyStimulus();
    tick();
    tick();

    // Reset state
    checkOutput("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    checkOutput("rst_req_ready", {61'd0, req_ready}, 64'd0);
    checkOutput("rst_done", {61'd0, done}, 64'd0);
    checkOutput("rst_err", {63'd0, err}, 64'd0);
    checkOutput("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
    rst = 1'b0;
    tick();

    // Single 4-beat read for requester 1
    $display("[TB] single read");
    baddr[1] = 23'h100; blen[1] = 4'd3; bwe[1] = 1'b0;
    applyStimulus();
    req_valid = 3'b010;
    serve(1, 1'b0, 1'b1);
    tick();

    // Two-beat write for requester 2, with a gap cycle between beats
    $display("[TB] write burst");
    baddr[2] = 23'h2000; blen[2] = 4'd1; bwe[2] = 1'b1;
    applyStimulus();
    req_valid = 3'b100;
    serve(2, 1'b0, 1'b1);
    tick();

    // Contention: all three held valid, pointer is back at 0
    $display("[TB] contention");
    baddr[0] = 23'h10; blen[0] = 4'd0; bwe[0] = 1'b0;
    baddr[1] = 23'h20; blen[1] = 4'd1; bwe[1] = 1'b0;
    baddr[2] = 23'h30; blen[2] = 4'd0; bwe[2] = 1'b1;
    applyStimulus();
    req_valid = 3'b111;
    serve(0, 1'b0, 1'b0);
    serve(1, 1'b1, 1'b0);
    serve(2, 1'b0, 1'b0);
    serve(0, 1'b0, 1'b1);
    tick();

    // Stray controller strobes in IDLE must not reach any requester
    $display("[TB] stray strobes");
    mem_rvalid = 1'b1;
    mem_wready = 1'b1;
    mem_done   = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    #1;
    checkOutput("stray_rd_valid", {61'd0, rd_valid}, 64'd0);
    checkOutput("stray_wr_ready", {61'd0, wr_ready}, 64'd0);
    checkOutput("stray_done", {61'd0, done}, 64'd0);
    tick();
    mem_rvalid = 1'b0;
    mem_wready = 1'b0;
    mem_done   = 1'b0;
    tick();

    // Watchdog: controller accepts requester 1 then goes silent
    $display("[TB] timeout");
    checkOutput("err_cnt_before_timeout", {56'd0, err_cnt}, 64'd0);
    baddr[1] = 23'h300; blen[1] = 4'd2; bwe[1] = 1'b0;
    applyStimulus();
    req_valid = 3'b010;
    sb.push_back(mk(0, 1, {9'd0, baddr[1]}, {27'd0, bwe[1], blen[1]}));
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    req_valid = 3'b000;
    sb.push_back(mk(3, 1, 32'd0, 32'd1));
    seen = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done != 3'b000) begin
        seen = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    tick();
    checkOutput("timeout_xfer_cycle", 64'(seen), 64'd15);
    checkOutput("err_cnt_after_timeout", {56'd0, err_cnt}, 64'd1);
    checkOutput("err_pulse_width", {63'd0, err}, 64'd0);

    // Next request after an abort is served normally
    baddr[1] = 23'h340; blen[1] = 4'd0;
    applyStimulus();
    req_valid = 3'b010;
    serve(1, 1'b0, 1'b1);
    tick();

    // Reset in the middle of a read burst for requester 2
    $display("[TB] reset mid-burst");
    baddr[2] = 23'h400; blen[2] = 4'd3; bwe[2] = 1'b0;
    applyStimulus();
    req_valid = 3'b100;
    sb.push_back(mk(0, 2, {9'd0, baddr[2]}, {27'd0, bwe[2], blen[2]}));
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    req_valid = 3'b000;
    mem_rdata  = 32'hBEEF_0000;
    mem_rvalid = 1'b1;
    sb.push_back(mk(2, 2, 32'd0, 32'hBEEF_0000));
    tick();
    mem_rdata = 32'hBEEF_0001;
    mem_done  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_rd_valid", {61'd0, rd_valid}, 64'd0);
    checkOutput("rst_mid_rd_data", {32'd0, rd_data}, 64'd0);
    checkOutput("rst_mid_done", {61'd0, done}, 64'd0);
    checkOutput("rst_mid_mem_valid", {63'd0, mem_valid}, 64'd0);
    checkOutput("rst_mid_err_cnt", {56'd0, err_cnt}, 64'd0);
    tick();
    mem_rvalid = 1'b0;
    mem_done   = 1'b0;
    rst        = 1'b0;
    tick();
    checkOutput("rst_mid_scoreboard_empty", 64'(sb.size()), 64'd0);

    // First arbitration after reset favours requester 0
    baddr[0] = 23'h500; blen[0] = 4'd1; bwe[0] = 1'b0;
    applyStimulus();
    req_valid = 3'b111;
    serve(0, 1'b0, 1'b1);
    tick();
    tick();

    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
